// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
// The optional header state is used only when UART_TX_ARB_HDR_EN is defined.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData,
        StGap
    } arb_state_e;

    localparam logic [7:0] HDR_MARK_DEFAULT = 8'hF0;

    // Widest data word the header helper supports.
    localparam int unsigned HDR_MAX_W = 64;

    // Header word: marker bits above the ID field, requester ID in the low id_width bits.
    function automatic logic [HDR_MAX_W-1:0] build_hdr(
        input logic [HDR_MAX_W-1:0] mark,
        input logic [HDR_MAX_W-1:0] id,
        input int unsigned          id_width
    );
        logic [HDR_MAX_W-1:0] mask;
        mask = (HDR_MAX_W'(1) << id_width) - HDR_MAX_W'(1);
        return (mark & ~mask) | (id & mask);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant,
// wrapping from NUM_REQ-1 back to 0.
module uart_rr_pick #(
    parameter int unsigned   NUM_REQ  = 4,
    localparam int unsigned  ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic                any,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] id
);

    always_comb begin
        any   = 1'b0;
        grant = '0;
        id    = '0;
        // Upper segment first; if empty, the second pass covers 0..last_grant.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (ID_WIDTH'(i) > last_grant)) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                id       = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                id       = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
// Define UART_TX_ARB_HDR_EN to prefix each payload with an ID-tagged header byte.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter int unsigned            NUM_REQ    = 4,
    parameter logic [DATA_WIDTH-1:0]  HDR_MARK   = DATA_WIDTH'(HDR_MARK_DEFAULT),
    localparam int unsigned           ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [DATA_WIDTH-1:0]               tx_data,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    output logic [ID_WIDTH-1:0]                 grant_id,
    output logic                                busy
);

    arb_state_e            state_q;
    logic                  tx_valid_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [ID_WIDTH-1:0]   grant_id_q;
    logic [ID_WIDTH-1:0]   last_grant_q;

    logic                  pick_any;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [ID_WIDTH-1:0]   pick_id;

    uart_rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .any        (pick_any),
        .grant      (pick_gnt),
        .id         (pick_id)
    );

`ifdef UART_TX_ARB_HDR_EN
    logic [DATA_WIDTH-1:0] word_q;
    logic                  data_pend_q;
    logic [DATA_WIDTH-1:0] hdr_word;

    assign hdr_word = DATA_WIDTH'(build_hdr(HDR_MAX_W'(HDR_MARK), HDR_MAX_W'(pick_id), ID_WIDTH));
`else
    logic unused_hdr_mark;

    assign unused_hdr_mark = ^HDR_MARK;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
`ifdef UART_TX_ARB_HDR_EN
            word_q       <= '0;
            data_pend_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_id_q   <= pick_id;
                        last_grant_q <= pick_id;
                        tx_valid_q   <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
                        word_q       <= req_data[pick_id];
                        tx_data_q    <= hdr_word;
                        state_q      <= StHdr;
`else
                        tx_data_q    <= req_data[pick_id];
                        state_q      <= StData;
`endif
                    end
                end
`ifdef UART_TX_ARB_HDR_EN
                StHdr: begin
                    if (tx_ready) begin
                        tx_valid_q  <= 1'b0;
                        data_pend_q <= 1'b1;
                        state_q     <= StGap;
                    end
                end
`endif
                StData: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StGap;
                    end
                end
                StGap: begin
`ifdef UART_TX_ARB_HDR_EN
                    if (data_pend_q) begin
                        // Header already out: payload follows without re-arbitrating.
                        data_pend_q <= 1'b0;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= word_q;
                        state_q     <= StData;
                    end else begin
                        tx_data_q  <= '0;
                        grant_id_q <= '0;
                        state_q    <= StIdle;
                    end
`else
                    tx_data_q  <= '0;
                    grant_id_q <= '0;
                    state_q    <= StIdle;
`endif
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    // Gated by rstn so no producer drops a word while the arbiter is held in reset.
    always_comb begin
        req_ready = '0;
        if (rstn && (state_q == StIdle)) begin
            req_ready = pick_gnt;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus random traffic against a
// queue-based reference model and a behavioural serializer that drops ready per frame.
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0][DW-1:0]   req_data;
    logic [NR-1:0]           req_ready;
    logic [DW-1:0]           tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [IW-1:0]           grant_id;
    logic                    busy;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Producers, reference model and serializer model.
    logic [7:0] prod_q [NR][$];
    logic [NR-1:0] mask;
    int         last_ptr;
    logic [7:0] m_q[$];
    bit         m_gap;
    logic [7:0] m_last;
    int         m_gid;
    int         srl_cnt;
    bit         hold_low;
    int         frame_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int i;
        for (int k = 1; k <= NR; k++) begin
            i = (last_ptr + k) % NR;
            if (mask[i] && prod_q[i].size() > 0) return i;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = mask[i] && (prod_q[i].size() > 0);
            req_data[i]  = (prod_q[i].size() > 0) ? prod_q[i][0] : 8'h00;
        end
        tx_ready = (srl_cnt == 0) && !hold_low;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_gap    = 1'b0;
        m_last   = 8'h00;
        m_gid    = 0;
        last_ptr = NR - 1;
        srl_cnt  = 0;
        hold_low = 1'b0;
    endtask

    task automatic push_word(input int r, input logic [7:0] d);
        prod_q[r].push_back(d);
    endtask

    function automatic bit model_idle();
        return (m_q.size() == 0) && !m_gap;
    endfunction

    // One clock: check outputs at negedge, then advance model at posedge, drive at +1.
    task automatic cycle();
        int         w;
        bit         ev;
        bit         eb;
        bit         acc;
        logic [7:0] ed;
        logic [31:0] rr;
        @(negedge clk);
        w  = pick();
        eb = !model_idle();
        ev = (m_q.size() > 0) && !m_gap;
        ed = m_gap ? m_last : ((m_q.size() > 0) ? m_q[0] : 8'h00);
        rr = (!eb && w >= 0) ? (32'd1 << w) : 32'd0;
        check("req_ready", 32'(req_ready), rr);
        check("tx_valid", 32'(tx_valid), 32'(ev));
        check("tx_data", 32'(tx_data), 32'(ed));
        check("grant_id", 32'(grant_id), eb ? 32'(m_gid) : 32'd0);
        check("busy", 32'(busy), 32'(eb));
        acc = ev && tx_ready;
        @(posedge clk);
        if (srl_cnt > 0) srl_cnt--;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (acc) begin
            m_last  = m_q.pop_front();
            m_gap   = 1'b1;
            srl_cnt = $urandom_range(frame_max, 1);
        end
        if (!eb && w >= 0) begin
            last_ptr = w;
            m_gid    = w;
`ifdef UART_TX_ARB_HDR_EN
            m_q.push_back(8'hF0 | 8'(w));
`endif
            m_q.push_back(prod_q[w].pop_front());
        end
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    function automatic bit all_drained();
        for (int i = 0; i < NR; i++) if (mask[i] && prod_q[i].size() > 0) return 1'b0;
        return model_idle();
    endfunction

    task automatic drain(input string tag);
        int budget;
        budget = 5000;
        while (!all_drained() && budget > 0) begin
            cycle();
            budget--;
        end
        check({tag, "_budget"}, 32'(budget > 0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int budget;
        mask      = '0;
        frame_max = 10;
        model_reset();
        drive_inputs();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #3 rstn = 1'b1;

        // Single requester 2 with 8'h5A.
        mask = 4'b0100;
        push_word(2, 8'h5A);
        drive_inputs();
        drain("t1");

        // All four after reset: order 0,1,2,3.
        rstn = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NR; i++) push_word(i, 8'h10 + 8'(i));
        mask = 4'hF;
        drive_inputs();
        @(posedge clk);
        #3 rstn = 1'b1;
        drain("t2");

        // Requesters 1 and 3 continuously valid: must alternate.
        mask      = 4'b1010;
        frame_max = 3;
        for (int k = 0; k < 4; k++) begin
            push_word(1, 8'hA0 + 8'(k));
            push_word(3, 8'hB0 + 8'(k));
        end
        drive_inputs();
        drain("t3");

        // Backpressure: ready held low for 500 cycles with others waiting.
        mask = 4'hF;
        for (int i = 0; i < NR; i++) push_word(i, 8'hC0 + 8'(i));
        hold_low = 1'b1;
        drive_inputs();
        run(500);
        hold_low = 1'b0;
        drive_inputs();
        drain("t4");

        // Reset while the payload is being presented.
        push_word(2, 8'h3C);
        push_word(3, 8'h4D);
        hold_low = 1'b1;
        drive_inputs();
        budget = 50;
        while (!((m_q.size() > 0) && !m_gap) && budget > 0) begin
            cycle();
            budget--;
        end
        check("t5_reach_data", 32'(budget > 0), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_all_zero("t5_async");
        model_reset();
        for (int i = 0; i < NR; i++) begin
            prod_q[i].delete();
            push_word(i, 8'h60 + 8'(i));
        end
        drive_inputs();
        #1;
        check("t5_no_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #3 rstn = 1'b1;
        drain("t5");

        // Random traffic.
        for (int r = 0; r < 25; r++) begin
            mask      = 4'($urandom_range(15, 0));
            frame_max = $urandom_range(15, 1);
            for (int i = 0; i < NR; i++) begin
                int n;
                n = $urandom_range(2, 0);
                for (int k = 0; k < n; k++) push_word(i, 8'($urandom));
            end
            drive_inputs();
            run(100);
        end
        mask = 4'hF;
        drive_inputs();
        drain("rand");
        @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQ` independent byte producers. It sits directly in front of `uart_tx` and latches one requester's word. It presents that word on the serializer's valid/ready handshake, then waits for the serializer to go busy before granting again. An optional compiled-in header byte tags each payload with the requester's ID.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — word width; must equal `uart_tx` `DATA_WIDTH`.
- `NUM_REQ`, 4 — number of requesters, 2..16.
- `HDR_MARK`, 8'hF0 — header template; the low `ID_WIDTH` bits are replaced by the ID. Used only with the header feature.
- `ID_WIDTH`, `$clog2(NUM_REQ)` — localparam; requires `ID_WIDTH <= DATA_WIDTH`.

Ports:
- `clk` in 1 — single clock.
- `rstn` in 1 — reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ` — per-requester word available.
- `req_data` in `NUM_REQ` x `DATA_WIDTH` — per-requester word; held stable while `req_valid` is high.
- `req_ready` out `NUM_REQ` — one-hot accept strobe.
- `tx_data` out `DATA_WIDTH` — to `uart_tx` data.
- `tx_valid` out 1 — to `uart_tx` valid.
- `tx_ready` in 1 — from `uart_tx` ready; falls the cycle after acceptance and stays low for the whole frame.
- `grant_id` out `ID_WIDTH` — ID of the requester currently being served.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- States: IDLE, HDR (only with the macro), DATA, GAP.
- IDLE:
  - Combinational round-robin pick among `req_valid`, searching from `last_grant+1` and wrapping from `NUM_REQ-1` to 0.
  - `req_ready[winner]` = 1 combinationally, and only in IDLE.
  - On that edge: latch `req_data[winner]`, set `grant_id` and `last_grant` to winner, go to DATA (or HDR).
  - No valid request: stay in IDLE with all outputs low.
- HDR: `tx_valid`=1, `tx_data` = {`HDR_MARK[DATA_WIDTH-1:ID_WIDTH]`, `grant_id`}. On `tx_valid && tx_ready` go to GAP, then to DATA.
- DATA: `tx_valid`=1, `tx_data` = latched word. On `tx_valid && tx_ready` go to GAP, then to IDLE.
- GAP: exactly one cycle with `tx_valid`=0. This lets `tx_ready` fall so the same word is never issued twice.
- `tx_data` and `tx_valid` are registered. `tx_valid` drops on the accepting edge.
- Backpressure: `tx_ready` may stay low indefinitely. Meanwhile `tx_valid`, `tx_data` and `grant_id` hold, and no `req_ready` is issued.
- `req_valid` dropping after grant has no effect; the word is already latched.
- Reset values:
  - Outputs: `tx_valid`=0, `tx_data`=0, `req_ready`=0, `grant_id`=0, `busy`=0.
  - Internal: `last_grant`=`NUM_REQ-1`, so requester 0 wins first.
  - State: IDLE.
- Reset mid-operation: asynchronous return to reset values in any state. The latched word is discarded and not re-sent. `uart_tx` shares `rstn`.

## Timing
- Request grant: zero-wait. If in IDLE at edge k with `req_valid[i]` high, the word is accepted at edge k and `tx_valid` is high after k.
- Serializer accept happens at the first edge j >= k+1 with `tx_ready`=1. GAP covers j to j+1, and the block is IDLE again after j+1.
- Minimum grant-to-grant spacing is 3 cycles plus serializer busy time. A full frame (10 bit times) dominates.
- With the header, a payload costs two frames. The header and data are never interleaved with another requester.
- Simultaneous requests resolve in one cycle by the round-robin pointer, never by fixed index except after reset.

## Configuration
- Macro: `UART_TX_ARB_HDR_EN`.
- Defined: the HDR state exists and each grant emits the header then the payload on `tx_data`.
- Undefined: the HDR state is removed, each grant emits only the payload, and `HDR_MARK` is unused.

## Structure
- Package `uart_arb_pkg`:
  - state enum `arb_state_e` (IDLE, HDR, DATA, GAP);
  - `HDR_MARK_DEFAULT` constant;
  - helper function building the header word from the marker and ID.
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs are the request vector and `last_grant`; outputs are `any`, one-hot grant and encoded ID. It is reused by the arbiter FSM.

## Test plan
Use `NUM_REQ`=4, 100 MHz, 9600 baud (10416 clocks/bit), with a real `uart_tx` downstream.
1. `req_valid[2]`, `req_data[2]`=8'h5A → `req_ready[2]` pulses for 1 cycle and `grant_id`=2. The line carries start 0, bits 0,1,0,1,1,0,1,0 (LSB first), stop 1.
2. All four valid after reset with data 8'h10..8'h13 → frames in order 10, 11, 12, 13; each `req_ready` pulses exactly once.
3. `req_valid[1]` and `req_valid[3]` held high continuously → grants alternate 1,3,1,3; no starvation.
4. Hold `tx_ready` low for 500 cycles while in DATA → `tx_valid`=1 and `tx_data` stay stable, and all `req_ready` stay 0 for 500 cycles.
5. Assert `rstn`=0 during DATA → all outputs go to 0 immediately. After release, with all requesters valid, requester 0 is granted first.
6. With `UART_TX_ARB_HDR_EN`, `req_valid[3]` and data 8'h77 → line frames 8'hF3 then 8'h77, back-to-back, with no other requester in between.
